// File: rtl/fifo_reader.sv
// fifo_reader: issues reads to a FIFO with one-cycle read latency and feeds
// the returned words into a 2-entry skid buffer. The buffer is presented as a
// valid/ready stream. A credit rule stops the buffer from ever being
// over-committed.
// Optional feature: define FIFO_READER_STATS_EN to build the word/error
// statistics counters. Without it, both counter outputs are tied to zero.
module fifo_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_d_out,
    input  logic                  fifo_rd_ack,
    input  logic                  fifo_rd_err,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  err_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;
    logic                  pending;
    logic                  drop_ack;
    logic                  pop;
    logic                  capture;
    logic                  room;
    logic                  wr_slot0;
    logic                  wr_slot1;
    logic [2:0]            committed;
    logic [2:0]            allowance;

    // slot0 is always the head of the stream, so the output needs no mux
    assign m_valid = (state != EMPTY);
    assign m_data  = slot0;

    // A flush cycle may see m_valid && m_ready, but that is not a transfer
    assign pop = m_valid && m_ready && !flush;

    // drop_ack hides the ack in the cycle after a flush or reset release,
    // because that ack belongs to a read issued before the discard
    assign capture = fifo_rd_ack && !fifo_rd_err && !flush && !drop_ack;

    // The credit test is 2 - occ - pending + pop >= 1, rearranged so it needs
    // no signed arithmetic: occ + pending <= 1 + pop
    assign committed = 3'(state) + 3'(pending);
    assign allowance = 3'd1 + 3'(pop);
    assign room      = (committed <= allowance);

    // Reset also blocks the request so nothing is issued while in reset
    assign fifo_rd_en = reset_n && en && !flush && !fifo_empty && room;

    // The tail slot depends on how many words stay after this cycle's pop.
    // A capture while FULL without a pop has no free slot and is dropped.
    assign wr_slot0 = capture && ((state == EMPTY) || ((state == ONE) && pop));
    assign wr_slot1 = capture && (((state == ONE) && !pop) || ((state == FULL) && pop));

    // Occupancy state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Occupancy transitions from capture/pop, with flush emptying the buffer
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (capture) begin
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (capture && !pop) begin
                        state_next = FULL;
                    end else if (!capture && pop) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (pop && !capture) begin
                        state_next = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // Buffer storage: shift forward on pop, then write the tail on capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot0 <= '0;
            slot1 <= '0;
        end else if (!flush) begin
            if (pop) begin
                slot0 <= slot1;
            end
            if (wr_slot0) begin
                slot0 <= fifo_d_out;
            end
            if (wr_slot1) begin
                slot1 <= fifo_d_out;
            end
        end
    end

    // Track the one read in flight, and arm the ack filter after flush/reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= 1'b0;
            drop_ack <= 1'b1;
        end else begin
            pending  <= fifo_rd_en;
            drop_ack <= flush;
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [CNT_WIDTH-1:0] word_cnt;
    logic [CNT_WIDTH-1:0] err_cnt;

    // Statistics: delivered words and read errors, both wrapping naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (pop) begin
                word_cnt <= word_cnt + CNT_WIDTH'(1);
            end
            if (fifo_rd_err) begin
                err_cnt <= err_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign word_count = word_cnt;
    assign err_count  = err_cnt;
`else
    assign word_count = '0;
    assign err_count  = '0;
`endif

endmodule
